// File: rtl/map_memory_if.sv
// Loader/solver bus for the maze map store.
// Latency: n/a (signal bundle only).
// Backpressure: none; loader and solver drive strobes, memory returns pulses/status.
//
// master: loader + solver side (drives command/enable/address/data/rd_en/rd_addr)
// slave : map_memory side (drives rd_data/rd_valid/map_ready/load_error/cell_count)
`timescale 1ns/1ps
interface map_memory_if #(
  parameter int MEMORYSIZE = 2
);
  logic                  command;
  logic                  enable;
  logic [5:0]            address;
  logic [MEMORYSIZE-1:0] data;
  logic                  rd_en;
  logic [5:0]            rd_addr;
  logic [MEMORYSIZE-1:0] rd_data;
  logic                  rd_valid;
  logic                  map_ready;
  logic                  load_error;
  logic [6:0]            cell_count;

  modport master (
    output command, enable, address, data, rd_en, rd_addr,
    input  rd_data, rd_valid, map_ready, load_error, cell_count
  );

  modport slave (
    input  command, enable, address, data, rd_en, rd_addr,
    output rd_data, rd_valid, map_ready, load_error, cell_count
  );
endinterface

// File: rtl/map_memory.sv
// Maze map store: loader fills 64 cells, then the map locks for solver reads.
// Latency: read data one cycle after rd_en (READY only); status flags update on the sampling edge.
// Backpressure: none; reads outside READY return a zero pulse-free response, nothing is queued.
//
// Ports: clk, rst (async active-low), bus (map_memory_if.slave):
//   command/enable/address/data = loader write port, rd_en/rd_addr -> rd_data/rd_valid,
//   map_ready/load_error/cell_count = load status.
`timescale 1ns/1ps
module map_memory #(
  parameter int MEMORYSIZE = 2,
  parameter int CELLS      = 64
) (
  input  logic         clk,
  input  logic         rst,
  map_memory_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [6:0] FULL = 7'(CELLS);

  state_t                state;
  state_t                next_state;

  logic [MEMORYSIZE-1:0] mem [CELLS];
  logic [CELLS-1:0]      written;
  logic [6:0]            cell_count;
  logic                  load_error;
  logic                  rd_valid;
  logic [MEMORYSIZE-1:0] rd_data;

  logic                  wr_accept;
  logic                  reload;
  logic                  set_error;
  logic                  rd_hit;

  // rst is used directly as the async clear: flops act on the first rising
  // edge after rst goes high, so no extra synchroniser cycles are added.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Equality compares are used on enable/command so an undriven (X/Z) bus in
  // READY/FAULT falls through to "hold" rather than triggering an action.
  always_comb begin
    next_state = state;
    wr_accept  = 1'b0;
    reload     = 1'b0;
    set_error  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.enable == 1'b0 && bus.command == 1'b1) begin
          wr_accept  = 1'b1;
          next_state = LOAD;
        end
      end
      LOAD: begin
        if (bus.enable == 1'b0) begin
          if (bus.command == 1'b1) wr_accept = 1'b1;
        end else if (bus.enable == 1'b1) begin
          if (cell_count == FULL) begin
            next_state = READY;
          end else begin
            next_state = FAULT;
            set_error  = 1'b1;
          end
        end
      end
      READY: begin
        if (bus.enable == 1'b0) begin
          if (bus.command == 1'b1) begin
            // map is locked: a write here is a protocol error, not a write
            next_state = FAULT;
            set_error  = 1'b1;
          end else if (bus.command == 1'b0) begin
            reload     = 1'b1;
            next_state = LOAD;
          end
        end
      end
      FAULT: begin
        if (bus.enable == 1'b0 && bus.command == 1'b0) begin
          reload     = 1'b1;
          next_state = LOAD;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Reads are decided on the current state, so a read issued on the same
  // edge as a reload still returns the old data.
  assign rd_hit = (bus.rd_en == 1'b1) && (state == READY);

  // Cell storage carries no reset; it is only observable once READY.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[bus.address] <= bus.data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      written    <= '0;
      cell_count <= '0;
      load_error <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
    end else begin
      if (reload) begin
        written    <= '0;
        cell_count <= '0;
      end else if (wr_accept) begin
        written[bus.address] <= 1'b1;
        // only first writes to a cell count; saturate at a full map
        if (!written[bus.address] && cell_count < FULL)
          cell_count <= cell_count + 7'd1;
      end
      if (set_error) load_error <= 1'b1;
      rd_valid <= rd_hit;
      rd_data  <= rd_hit ? mem[bus.rd_addr] : '0;
    end
  end

  assign bus.rd_data    = rd_data;
  assign bus.rd_valid   = rd_valid;
  assign bus.map_ready  = (state == READY);
  assign bus.load_error = load_error;
  assign bus.cell_count = cell_count;

endmodule

// File: tb/tb_map_memory.sv
// Directed bench for map_memory with a read-response scoreboard.
// Latency: expects read responses one cycle after rd_en.
// Backpressure: none exercised; DUT has no stall path.
`timescale 1ns/1ps
module tb_map_memory;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  map_memory_if #(.MEMORYSIZE(2)) bus ();

  map_memory #(.MEMORYSIZE(2), .CELLS(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // expected {rd_valid, rd_data} per issued read, plus a tag for reporting
  logic [2:0] exp_q [$];
  int         tag_q [$];
  logic       rd_issued = 1'b0;

  always @(posedge clk) rd_issued <= bus.rd_en;

  // monitor: compare a response slot whenever a read was issued last cycle
  // or the DUT claims a valid response
  always @(negedge clk) begin
    if (rst && (rd_issued || bus.rd_valid)) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rd_unexpected: got vld=%0b dat=%0d, required no response",
                 bus.rd_valid, bus.rd_data);
      end else begin
        logic [2:0] e;
        int t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        if ({bus.rd_valid, bus.rd_data} !== e) begin
          n_err++;
          $display("FAIL rd_%0d: got vld=%0b dat=%0d, required vld=%0b dat=%0d",
                   t, bus.rd_valid, bus.rd_data, e[2], e[1:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic cmd, input logic en, input logic [5:0] ad,
                       input logic [1:0] dt);
    @(negedge clk);
    bus.command = cmd;
    bus.enable  = en;
    bus.address = ad;
    bus.data    = dt;
    bus.rd_en   = 1'b0;
    bus.rd_addr = 6'd0;
  endtask

  task automatic rd(input logic [5:0] a, input logic ev, input logic [1:0] ed,
                    input int tag);
    @(negedge clk);
    bus.command = 1'b0;
    bus.enable  = 1'b1;
    bus.rd_en   = 1'b1;
    bus.rd_addr = a;
    exp_q.push_back({ev, ed});
    tag_q.push_back(tag);
  endtask

  task automatic hold_z();
    @(negedge clk);
    bus.command = 1'b0;
    bus.enable  = 1'b1;
    bus.address = 'z;
    bus.data    = 'z;
    bus.rd_en   = 1'b0;
  endtask

  // pattern 0: cell 12 is path, rest wall; 1: all wall; 2: odd cells wall
  function automatic logic [1:0] pat(input int p, input int a);
    logic [5:0] aa;
    aa = a[5:0];
    if (p == 0) return (a == 12) ? 2'd0 : 2'd1;
    if (p == 1) return 2'd1;
    return {1'b0, aa[0]};
  endfunction

  task automatic load(input int first, input int last, input int p);
    for (int a = first; a <= last; a++) drive(1'b1, 1'b0, a[5:0], pat(p, a));
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
  endtask

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: got no completion, required finish before 200000ns");
    summary();
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.command = 1'b0;
    bus.enable  = 1'b1;
    bus.address = 6'd0;
    bus.data    = 2'd0;
    bus.rd_en   = 1'b0;
    bus.rd_addr = 6'd0;

    // reset state, idle behaviour
    repeat (3) @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b1, 6'd0, 2'd0);
    chk("rst_map_ready", bus.map_ready, 0);
    chk("rst_load_error", bus.load_error, 0);
    chk("rst_cell_count", bus.cell_count, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    rd(6'd0, 1'b0, 2'd0, 0);                   // read in IDLE: empty response
    drive(1'b1, 1'b1, 6'd3, 2'd1);             // command with enable=1: ignored
    drive(1'b0, 1'b1, 6'd0, 2'd0);
    drive(1'b0, 1'b1, 6'd0, 2'd0);
    chk("idle_cell_count", bus.cell_count, 0);
    chk("idle_load_error", bus.load_error, 0);

    // full load, cell 12 = path
    load(0, 63, 0);
    drive(1'b0, 1'b1, 6'd0, 2'd0);
    chk("full_cnt_before_en", bus.cell_count, 64);
    chk("full_ready_before_en", bus.map_ready, 0);
    drive(1'b0, 1'b1, 6'd0, 2'd0);
    chk("full_map_ready", bus.map_ready, 1);
    chk("full_load_error", bus.load_error, 0);
    chk("full_cell_count", bus.cell_count, 64);
    rd(6'd12, 1'b1, 2'd0, 12);
    rd(6'd11, 1'b1, 2'd1, 11);
    rd(6'd63, 1'b1, 2'd1, 63);
    drive(1'b0, 1'b1, 6'd0, 2'd0);

    // write attempt while locked
    drive(1'b1, 1'b0, 6'd12, 2'd1);
    drive(1'b0, 1'b1, 6'd0, 2'd0);
    chk("lockwr_load_error", bus.load_error, 1);
    chk("lockwr_map_ready", bus.map_ready, 0);
    chk("lockwr_cell_count", bus.cell_count, 64);

    // reset clears sticky error
    #2 rst = 1'b0;
    #1;
    chk("rst2_load_error", bus.load_error, 0);
    chk("rst2_cell_count", bus.cell_count, 0);
    @(negedge clk);
    rst = 1'b1;

    // short load: 63 cells
    load(0, 62, 1);
    drive(1'b0, 1'b1, 6'd0, 2'd0);
    drive(1'b0, 1'b1, 6'd0, 2'd0);
    chk("short_load_error", bus.load_error, 1);
    chk("short_map_ready", bus.map_ready, 0);
    chk("short_cell_count", bus.cell_count, 63);
    rd(6'd0, 1'b0, 2'd0, 100);
    rd(6'd62, 1'b0, 2'd0, 101);
    drive(1'b0, 1'b1, 6'd0, 2'd0);

    // reload from FAULT, cell 5 written twice
    drive(1'b0, 1'b0, 6'd0, 2'd0);
    drive(1'b1, 1'b0, 6'd0, 2'd1);
    chk("reload_cell_count", bus.cell_count, 0);
    chk("reload_load_error", bus.load_error, 1);
    load(1, 63, 1);
    drive(1'b1, 1'b0, 6'd5, 2'd0);
    drive(1'b0, 1'b1, 6'd0, 2'd0);
    chk("dup_cell_count", bus.cell_count, 64);
    drive(1'b0, 1'b1, 6'd0, 2'd0);
    chk("dup_map_ready", bus.map_ready, 1);
    rd(6'd5, 1'b1, 2'd0, 5);
    rd(6'd12, 1'b1, 2'd1, 212);

    // bus released (Z) for 100 cycles with interleaved reads
    for (int i = 0; i < 100; i++) begin
      if (i % 10 == 0) begin
        logic [5:0] a;
        a = (i == 0) ? 6'd5 : 6'((i / 10) * 7);
        rd(a, 1'b1, (a == 6'd5) ? 2'd0 : 2'd1, 300 + i);
      end else begin
        hold_z();
      end
    end
    hold_z();
    chk("z_map_ready", bus.map_ready, 1);
    chk("z_cell_count", bus.cell_count, 64);

    // read and reload on the same edge: read completes with old data
    @(negedge clk);
    bus.command = 1'b0;
    bus.enable  = 1'b0;
    bus.address = 6'd0;
    bus.data    = 2'd0;
    bus.rd_en   = 1'b1;
    bus.rd_addr = 6'd5;
    exp_q.push_back({1'b1, 2'd0});
    tag_q.push_back(400);
    drive(1'b1, 1'b0, 6'd0, pat(2, 0));
    chk("samedge_map_ready", bus.map_ready, 0);
    chk("samedge_cell_count", bus.cell_count, 0);

    // reset mid-load after 30 writes
    load(1, 29, 2);
    drive(1'b0, 1'b0, 6'd0, 2'd0);
    chk("mid_cell_count", bus.cell_count, 30);
    #2 rst = 1'b0;
    #1;
    chk("midrst_cell_count", bus.cell_count, 0);
    chk("midrst_load_error", bus.load_error, 0);
    chk("midrst_map_ready", bus.map_ready, 0);
    chk("midrst_rd_valid", bus.rd_valid, 0);
    chk("midrst_rd_data", bus.rd_data, 0);
    @(negedge clk);
    rst = 1'b1;
    bus.command = 1'b0;
    bus.enable  = 1'b1;
    load(0, 63, 2);
    drive(1'b0, 1'b1, 6'd0, 2'd0);
    drive(1'b0, 1'b1, 6'd0, 2'd0);
    chk("post_map_ready", bus.map_ready, 1);
    chk("post_cell_count", bus.cell_count, 64);
    chk("post_load_error", bus.load_error, 0);
    rd(6'd3, 1'b1, 2'd1, 503);
    rd(6'd4, 1'b1, 2'd0, 504);
    repeat (4) drive(1'b0, 1'b1, 6'd0, 2'd0);
    chk("scoreboard_drained", exp_q.size(), 0);

    summary();
    $finish;
  end

endmodule
